// File: rtl/nco_sincos_multi.sv
// Multi-channel sin/cos NCO: round-robin accumulators, shared interpolated half-wave LUT.
// Optional macro PHASE_DITHER_EN adds LFSR phase dither ahead of truncation.
module nco_sincos_multi #(
   parameter int CHANNELS    = 4,
   parameter int PHASE_BITS  = 32,
   parameter int INPUT_BITS  = 16,
   parameter int LUT_BITS    = 6,
   parameter int OUTPUT_BITS = 16,
   localparam int CH_BITS    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          freq_wr,
   input  logic [CH_BITS-1:0]            freq_ch,
   input  logic [PHASE_BITS-1:0]         freq_word,
   input  logic                          phase_clr,
   input  logic                          out_ready,
   output logic                          out_valid,
   output logic [CH_BITS-1:0]            out_ch,
   output logic signed [OUTPUT_BITS-1:0] out_sin,
   output logic signed [OUTPUT_BITS-1:0] out_cos
);
   localparam int IB    = INPUT_BITS - 1 - LUT_BITS;
   localparam int AW    = LUT_BITS + 1;
   localparam int PW    = OUTPUT_BITS + IB + 2;
   localparam int LUT_N = 1 << LUT_BITS;
   localparam real PI   = 3.14159265358979323846;
   localparam real AMP  = (2.0 ** (OUTPUT_BITS - 1)) - 1.0;
   localparam logic [AW-1:0] QTR  = AW'(1) << (LUT_BITS - 1);
   localparam logic [IB:0]   WONE = (IB + 1)'(1) << IB;

   logic signed [OUTPUT_BITS-1:0] lut [LUT_N];

   for (genvar g = 0; g < LUT_N; g++) begin : g_lut
      localparam int VAL = $rtoi($sin(real'(g) * PI / LUT_N) * AMP);
      assign lut[g] = VAL[OUTPUT_BITS-1:0];
   end

   logic [PHASE_BITS-1:0] acc  [CHANNELS];
   logic [PHASE_BITS-1:0] freq [CHANNELS];
   logic [CH_BITS-1:0]    seq;
   logic                  stall;
   logic                  adv;
   logic [PHASE_BITS-1:0] acc_cur;
   logic [INPUT_BITS-1:0] p;
   logic [AW-1:0]         s0;

   logic                  v1;
   logic [CH_BITS-1:0]    ch1;
   logic [AW-1:0]         a_s0, a_s1, a_c0, a_c1;
   logic [IB-1:0]         w1;

   logic                  v2;
   logic [CH_BITS-1:0]    ch2;
   logic signed [PW-1:0]  ps0, ps1, pc0, pc1;

   assign stall   = out_valid & ~out_ready;
   assign adv     = ~phase_clr & ~stall;
   assign acc_cur = acc[seq];
   assign s0      = p[INPUT_BITS-1:IB];

`ifdef PHASE_DITHER_EN
   localparam int DB = (PHASE_BITS - INPUT_BITS < 16) ? PHASE_BITS - INPUT_BITS : 16;
   logic [15:0]           lfsr;
   logic [PHASE_BITS-1:0] dith;

   // dither only perturbs the sampled phase, never the stored accumulator
   assign dith = PHASE_BITS'(lfsr[DB-1:0]);
   assign p    = INPUT_BITS'((acc_cur + dith) >> (PHASE_BITS - INPUT_BITS));

   always_ff @(posedge clk) begin
      if (reset)
         lfsr <= 16'hACE1;
      else if (adv)
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end
`else
   assign p = acc_cur[PHASE_BITS-1 -: INPUT_BITS];
`endif

   function automatic logic signed [OUTPUT_BITS-1:0] lut_val(input logic [AW-1:0] a);
      logic signed [OUTPUT_BITS-1:0] v;
      v = lut[a[LUT_BITS-1:0]];
      return a[LUT_BITS] ? -v : v;
   endfunction

   function automatic logic signed [PW-1:0] wmul(
      input logic signed [OUTPUT_BITS-1:0] v,
      input logic [IB:0]                   w
   );
      logic signed [PW-1:0] ve;
      logic signed [PW-1:0] we;
      ve = PW'(v);
      we = PW'(w);
      return ve * we;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         seq       <= '0;
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         out_ch    <= '0;
         out_sin   <= '0;
         out_cos   <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            acc[i]  <= '0;
            freq[i] <= '0;
         end
      end else begin
         if (freq_wr && (32'(freq_ch) < CHANNELS))
            freq[freq_ch] <= freq_word;
         if (phase_clr) begin
            seq       <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            for (int i = 0; i < CHANNELS; i++)
               acc[i] <= '0;
         end else if (!stall) begin
            acc[seq] <= acc_cur + freq[seq];
            seq      <= (seq == CH_BITS'(CHANNELS - 1)) ? '0 : seq + 1'b1;
            // S1: addresses for both neighbours of sine and cosine
            v1   <= 1'b1;
            ch1  <= seq;
            a_s0 <= s0;
            a_s1 <= s0 + AW'(1);
            a_c0 <= s0 + QTR;
            a_c1 <= s0 + QTR + AW'(1);
            w1   <= p[IB-1:0];
            // S2: table read and weighting
            v2  <= v1;
            ch2 <= ch1;
            ps0 <= wmul(lut_val(a_s0), WONE - {1'b0, w1});
            ps1 <= wmul(lut_val(a_s1), {1'b0, w1});
            pc0 <= wmul(lut_val(a_c0), WONE - {1'b0, w1});
            pc1 <= wmul(lut_val(a_c1), {1'b0, w1});
            // S3: blend and rescale
            out_valid <= v2;
            out_ch    <= ch2;
            out_sin   <= OUTPUT_BITS'((ps0 + ps1) >>> IB);
            out_cos   <= OUTPUT_BITS'((pc0 + pc1) >>> IB);
         end
      end
   end

endmodule
